// File: rtl/vi_sync_pulse_pkg.sv
// Shared constants for the multi-channel clka-to-clkb pulse synchroniser.
package vi_sync_pulse_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Largest count the pending counter can hold for a given width.
    function automatic int pend_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/vi_sync_level.sv
// Multi-flop level synchroniser into the clk domain; resets asynchronously to zero.
module vi_sync_level #(
    parameter int SIZE   = 1,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] sync_q [STAGES];
    logic [SIZE-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vi_sync_pulse_ch.sv
// One pulse channel: clka pending counter and req toggle, clkb edge detect and ack toggle.
module vi_sync_pulse_ch
    import vi_sync_pulse_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clka,
    input  logic clkb,
    input  logic rst_n,
    input  logic in_pulse,
    input  logic ovf_clr,
    output logic out_pulse,
    output logic ovf,
    output logic busy
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));

    logic [CNT_W-1:0] pend_q, pend_d;
    logic             req_t_q, req_t_d;
    logic             inflight_q, inflight_d;
    logic             ovf_q, ovf_d;
    logic             ack_s;
    logic             launch;
    logic             ovf_evt;

    logic             req_s;
    logic             req_dly_q, req_dly_d;

    always_comb begin
        launch     = ~inflight_q & ((pend_q != '0) | in_pulse);
        req_t_d    = req_t_q ^ launch;
        inflight_d = inflight_q;
        pend_d     = pend_q;
        ovf_evt    = 1'b0;

        if (launch) begin
            inflight_d = 1'b1;
        end else if (inflight_q && (ack_s == req_t_q)) begin
            inflight_d = 1'b0;
        end

        // A launch coinciding with a new event leaves the count untouched.
        if (in_pulse && !launch) begin
            if (pend_q == PEND_MAX) begin
                ovf_evt = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!in_pulse && launch) begin
            pend_d = pend_q - 1'b1;
        end

        ovf_d = ovf_evt | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            req_t_q    <= 1'b0;
            inflight_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            req_t_q    <= req_t_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
        end
    end

    vi_sync_level #(.SIZE(1), .STAGES(STAGES)) u_req_sync (
        .clk   (clkb),
        .rst_n (rst_n),
        .d     (req_t_q),
        .q     (req_s)
    );

    // The delayed copy of req_s doubles as the ack toggle returned to clka.
    assign req_dly_d = req_s;

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            req_dly_q <= 1'b0;
        end else begin
            req_dly_q <= req_dly_d;
        end
    end

    vi_sync_level #(.SIZE(1), .STAGES(STAGES)) u_ack_sync (
        .clk   (clka),
        .rst_n (rst_n),
        .d     (req_dly_q),
        .q     (ack_s)
    );

    assign out_pulse = req_s ^ req_dly_q;
    assign ovf       = ovf_q;
    assign busy      = inflight_q | (pend_q != '0);

`ifndef SYNTHESIS
    ap_pulse_single: assert property (@(posedge clkb) disable iff (!rst_n)
        out_pulse |=> !out_pulse);
    ap_pend_no_wrap_hi: assert property (@(posedge clka) disable iff (!rst_n)
        (pend_q == PEND_MAX) |=> (pend_q >= PEND_MAX - 1'b1));
    ap_pend_no_wrap_lo: assert property (@(posedge clka) disable iff (!rst_n)
        (pend_q == '0) |=> (pend_q <= CNT_W'(1)));
    ap_no_launch_inflight: assert property (@(posedge clka) disable iff (!rst_n)
        launch |-> !inflight_q);
`endif

endmodule

// File: rtl/vi_sync_pulse_multi.sv
// NUM_CH independent clka-to-clkb pulse channels with queued replay and sticky overflow.
module vi_sync_pulse_multi
    import vi_sync_pulse_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clka,
    input  logic              clkb,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] in_pulse,
    input  logic [NUM_CH-1:0] ovf_clr,
    output logic [NUM_CH-1:0] out_pulse,
    output logic [NUM_CH-1:0] ovf,
    output logic [NUM_CH-1:0] busy,
    output logic              idle
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            vi_sync_pulse_ch #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clka      (clka),
                .clkb      (clkb),
                .rst_n     (rst_n),
                .in_pulse  (in_pulse[gi]),
                .ovf_clr   (ovf_clr[gi]),
                .out_pulse (out_pulse[gi]),
                .ovf       (ovf[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    assign idle = ~|busy;

endmodule

// File: tb/tb_vi_sync_pulse_multi.sv
// Scoreboard bench: stimulus queues one expected delivery per accepted event, a clkb monitor retires them.
module tb_vi_sync_pulse_multi;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int QMAX        = (1 << CNT_W) - 1;

    logic              clka = 1'b0;
    logic              clkb = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_CH-1:0] in_pulse = '0;
    logic [NUM_CH-1:0] ovf_clr = '0;
    logic [NUM_CH-1:0] out_pulse;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] busy;
    logic              idle;

    int ta_half = 50;
    int tb_half = 200;

    int n_vec = 0;
    int n_err = 0;
    int serial = 0;
    bit verbose = 1'b1;

    int exp_q [NUM_CH][$];
    int pulse_cnt [NUM_CH];
    int issued [NUM_CH];
    bit lossy [NUM_CH];

    vi_sync_pulse_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clka      (clka),
        .clkb      (clkb),
        .rst_n     (rst_n),
        .in_pulse  (in_pulse),
        .ovf_clr   (ovf_clr),
        .out_pulse (out_pulse),
        .ovf       (ovf),
        .busy      (busy),
        .idle      (idle)
    );

    initial forever #(ta_half) clka = ~clka;
    initial forever #(tb_half) clkb = ~clkb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_counts();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pulse_cnt[ch] = 0;
            issued[ch]    = 0;
        end
    endtask

    // One clka cycle of stimulus; every accepted event becomes an expected delivery.
    task automatic drive_cycle(input logic [NUM_CH-1:0] mask);
        @(negedge clka);
        in_pulse = mask;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask[ch]) begin
                serial++;
                issued[ch]++;
                if (!lossy[ch]) exp_q[ch].push_back(serial);
                if (verbose) $display("issue   ch%0d event %0d at %0t", ch, serial, $time);
            end
        end
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clka);
            done = (idle === 1'b1);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!lossy[ch] && exp_q[ch].size() != 0) done = 1'b0;
            end
        end
        if (!done) check({tag, "_drain_timeout"}, 0, 1);
        repeat (4) @(negedge clkb);
    endtask

    // Monitor: every high sample of out_pulse is one delivery.
    initial begin
        bit prev [NUM_CH];
        int ev;
        for (int ch = 0; ch < NUM_CH; ch++) prev[ch] = 1'b0;
        forever begin
            @(negedge clkb);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (out_pulse[ch] === 1'b1) begin
                    check($sformatf("pulse_gap_ch%0d", ch), 32'(prev[ch]), 0);
                    pulse_cnt[ch]++;
                    if (!lossy[ch]) begin
                        check($sformatf("pulse_expected_ch%0d", ch), 32'(exp_q[ch].size() != 0), 1);
                        if (exp_q[ch].size() != 0) begin
                            ev = exp_q[ch].pop_front();
                            if (verbose) $display("deliver ch%0d event %0d at %0t", ch, ev, $time);
                        end
                    end
                end
                prev[ch] = (out_pulse[ch] === 1'b1);
            end
        end
    end

    initial begin
        #(50_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        int cnt;
        int phase_ev;
        int iter;
        logic [NUM_CH-1:0] mask;

        for (int ch = 0; ch < NUM_CH; ch++) lossy[ch] = 1'b0;
        reset_counts();

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_pulse", 32'(out_pulse), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_idle", 32'(idle), 1);
        repeat (3) @(negedge clka);
        rst_n = 1'b1;

        // Single event, clka 100 MHz, clkb 25 MHz
        repeat (2) @(negedge clka);
        reset_counts();
        drive_cycle(4'b0001);
        drive_cycle(4'b0000);
        check("t1_busy_after_launch", 32'(busy[0]), 1);
        drain("t1");
        check("t1_count", pulse_cnt[0], 1);
        check("t1_idle", 32'(idle), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_ovf", 32'(ovf), 0);

        // Burst of 10, clka 200 MHz, clkb 20 MHz
        ta_half = 25;
        tb_half = 250;
        repeat (4) @(negedge clkb);
        reset_counts();
        repeat (10) drive_cycle(4'b0010);
        drive_cycle(4'b0000);
        drain("t2");
        check("t2_count", pulse_cnt[1], 10);
        check("t2_ovf", 32'(ovf), 0);

        // Burst of 20 saturates the 15-deep counter while the first is in flight
        lossy[2] = 1'b1;
        reset_counts();
        repeat (20) drive_cycle(4'b0100);
        drive_cycle(4'b0000);
        check("t3_ovf_set", 32'(ovf), 32'b0100);
        drain("t3");
        cnt = pulse_cnt[2];
        $display("burst20 ch2 delivered %0d", cnt);
        check("t3_count_in_range", 32'((cnt >= 16) && (cnt <= 20)), 1);
        @(negedge clka);
        ovf_clr = 4'b0100;
        @(negedge clka);
        ovf_clr = 4'b0000;
        check("t3_ovf_cleared", 32'(ovf), 0);
        lossy[2] = 1'b0;

        // All channels together, clkb faster
        ta_half = 100;
        tb_half = 33;
        repeat (4) @(negedge clka);
        reset_counts();
        repeat (3) drive_cycle(4'b1111);
        drive_cycle(4'b0000);
        drain("t4");
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("t4_count_ch%0d", ch), pulse_cnt[ch], 3);
        end

        // Reset with ch3 holding pend=5 and a request in flight
        ta_half = 25;
        tb_half = 100;
        repeat (4) @(negedge clkb);
        lossy[3] = 1'b1;
        repeat (6) drive_cycle(4'b1000);
        drive_cycle(4'b0000);
        check("t5_busy_before_rst", 32'(busy[3]), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_pulse", 32'(out_pulse), 0);
        check("t5_rst_ovf", 32'(ovf), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_idle", 32'(idle), 1);
        repeat (3) @(negedge clka);
        rst_n = 1'b1;
        reset_counts();
        repeat (50) @(negedge clkb);
        sum = 0;
        for (int ch = 0; ch < NUM_CH; ch++) sum += pulse_cnt[ch];
        check("t5_no_pulse_after_rst", sum, 0);
        check("t5_idle_after_rst", 32'(idle), 1);
        lossy[3] = 1'b0;

        // Random ratios, dense traffic kept below saturation
        verbose = 1'b0;
        for (int phase = 0; phase < 4; phase++) begin
            ta_half = $urandom_range(20, 60);
            tb_half = $urandom_range(20, 60);
            repeat (4) @(negedge clkb);
            reset_counts();
            phase_ev = 0;
            iter = 0;
            while (phase_ev < 1000 && iter < 40000) begin
                mask = '0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (exp_q[ch].size() < QMAX && $urandom_range(0, 1) == 1) mask[ch] = 1'b1;
                end
                drive_cycle(mask);
                phase_ev += $countones(mask);
                iter++;
            end
            drive_cycle(4'b0000);
            if (phase_ev < 1000) check($sformatf("rnd%0d_stimulus_stalled", phase), 0, 1);
            drain($sformatf("rnd%0d", phase));
            for (int ch = 0; ch < NUM_CH; ch++) begin
                check($sformatf("rnd%0d_count_ch%0d", phase, ch), pulse_cnt[ch], issued[ch]);
            end
            check($sformatf("rnd%0d_ovf", phase), 32'(ovf), 0);
            $display("random phase %0d: clka half %0d, clkb half %0d, %0d events", phase, ta_half, tb_half, phase_ev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
